// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one ALU between two requesters
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int SEL   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [SEL-1:0]   req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [SEL-1:0]   req1_sel,
  output logic [WIDTH-1:0] alu_inp1,
  output logic [WIDTH-1:0] alu_inp2,
  output logic [SEL-1:0]   alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  // Opcodes the ALU does not implement; their result is replaced by an error response.
  localparam logic [SEL-1:0] OP_BAD0 = SEL'(3'b011);
  localparam logic [SEL-1:0] OP_BAD1 = SEL'(3'b111);

  state_t state, state_nxt;
  logic   last_grant;
  logic   cur_id;
  logic   gnt_valid;
  logic   gnt_id;
  logic   grant;
  logic   bad_op;

  assign bad_op = (alu_sel == OP_BAD0) || (alu_sel == OP_BAD1);

  // Round-robin choice: contention favours the port not granted last time.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt_valid = 1'b1;
      gnt_id    = ~last_grant;
    end else if (req0_valid) begin
      gnt_valid = 1'b1;
      gnt_id    = 1'b0;
    end else if (req1_valid) begin
      gnt_valid = 1'b1;
      gnt_id    = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and grant strobe; ready is held low while reset is asserted.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_valid && rst_n) begin
          grant     = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req0_ready = grant & ~gnt_id;
  assign req1_ready = grant &  gnt_id;

  // Operand capture on grant, result capture after the EXEC cycle, release on rsp_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      cur_id     <= 1'b0;
      alu_inp1   <= '0;
      alu_inp2   <= '0;
      alu_sel    <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      if (grant) begin
        cur_id     <= gnt_id;
        last_grant <= gnt_id;
        alu_inp1   <= gnt_id ? req1_a   : req0_a;
        alu_inp2   <= gnt_id ? req1_b   : req0_b;
        alu_sel    <= gnt_id ? req1_sel : req0_sel;
      end
      if (state == EXEC) begin
        rsp_valid <= 1'b1;
        rsp_id    <= cur_id;
        if (bad_op) begin
          rsp_result <= '0;
          rsp_zero   <= 1'b1;
          rsp_err    <= 1'b1;
        end else begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_err    <= 1'b0;
        end
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter against a behavioural model
module tb_alu_arbiter;

  localparam int W = 32;

  typedef struct packed {
    logic         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   sel;
  } op_t;

  typedef struct packed {
    logic [W-1:0] result;
    logic         zero;
    logic         err;
  } rsp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]   req0_sel, req1_sel;
  logic [W-1:0] alu_inp1, alu_inp2, alu_result, rsp_result;
  logic [2:0]   alu_sel;
  logic         alu_zero, rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] sel);
    case (sel)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a + b;
      3'd3:    return a ^ b;
      3'd4:    return a - b;
      3'd5:    return a * b;
      3'd6:    return (a < b) ? 32'd1 : 32'd0;
      default: return ~a;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_inp1, alu_inp2, alu_sel);
  assign alu_zero   = (alu_result == '0);

  alu_arbiter #(.WIDTH(W), .SEL(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_sel(req1_sel),
    .alu_inp1(alu_inp1), .alu_inp2(alu_inp2), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  function automatic rsp_t resp_ref(input op_t o);
    rsp_t r;
    logic [W-1:0] v;
    if (o.sel == 3'b011 || o.sel == 3'b111) begin
      r.result = '0; r.zero = 1'b1; r.err = 1'b1;
    end else begin
      v = alu_fn(o.a, o.b, o.sel);
      r.result = v; r.zero = (v == '0); r.err = 1'b0;
    end
    return r;
  endfunction

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   n_rsp = 0;
  logic acc0, acc1;
  op_t  sb[$];
  logic m_pend_v, m_slot_v, m_last;
  op_t  m_pend, m_slot, m_alu;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend_v = 1'b0;
    m_slot_v = 1'b0;
    m_last   = 1'b1;
    m_alu    = '0;
    m_pend   = '0;
    m_slot   = '0;
    sb.delete();
  endtask

  // One clock: check ready and handshakes before the edge, then registered outputs after it.
  task automatic step();
    logic gv, gid;
    op_t  o;
    rsp_t e;
    #1;
    acc0 = req0_valid && req0_ready;
    acc1 = req1_valid && req1_ready;
    if (!rst_n) begin
      model_reset();
      chk1("rst_ready0", req0_ready, 1'b0);
      chk1("rst_ready1", req1_ready, 1'b0);
    end else begin
      gv = 1'b0; gid = 1'b0;
      if (!m_pend_v && !m_slot_v) begin
        if (req0_valid && req1_valid) begin gv = 1'b1; gid = ~m_last; end
        else if (req0_valid)          begin gv = 1'b1; gid = 1'b0;    end
        else if (req1_valid)          begin gv = 1'b1; gid = 1'b1;    end
      end
      chk1("ready0", req0_ready, gv && !gid);
      chk1("ready1", req1_ready, gv && gid);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chkw("rsp_without_op", 32'(sb.size()), 32'd1);
        end else begin
          o = sb.pop_front();
          e = resp_ref(o);
          chk1("sb_id", rsp_id, o.id);
          chkw("sb_result", rsp_result, e.result);
          chk1("sb_zero", rsp_zero, e.zero);
          chk1("sb_err", rsp_err, e.err);
          n_rsp++;
        end
      end
      if (acc0) sb.push_back('{1'b0, req0_a, req0_b, req0_sel});
      if (acc1) sb.push_back('{1'b1, req1_a, req1_b, req1_sel});
      if (m_slot_v && rsp_ready) m_slot_v = 1'b0;
      if (m_pend_v) begin m_slot = m_pend; m_slot_v = 1'b1; m_pend_v = 1'b0; end
      if (gv) begin
        m_pend   = gid ? '{1'b1, req1_a, req1_b, req1_sel} : '{1'b0, req0_a, req0_b, req0_sel};
        m_pend_v = 1'b1;
        m_last   = gid;
        m_alu    = m_pend;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      model_reset();
      chk1("rst_rsp_valid", rsp_valid, 1'b0);
      chk1("rst_rsp_id", rsp_id, 1'b0);
      chkw("rst_rsp_result", rsp_result, '0);
      chk1("rst_rsp_zero", rsp_zero, 1'b0);
      chk1("rst_rsp_err", rsp_err, 1'b0);
      chkw("rst_alu_inp1", alu_inp1, '0);
      chkw("rst_alu_inp2", alu_inp2, '0);
      chkw("rst_alu_sel", 32'(alu_sel), 32'd0);
    end else begin
      chk1("rsp_valid", rsp_valid, m_slot_v);
      if (m_slot_v) begin
        e = resp_ref(m_slot);
        chk1("rsp_id", rsp_id, m_slot.id);
        chkw("rsp_result", rsp_result, e.result);
        chk1("rsp_zero", rsp_zero, e.zero);
        chk1("rsp_err", rsp_err, e.err);
      end
      chkw("alu_inp1", alu_inp1, m_alu.a);
      chkw("alu_inp2", alu_inp2, m_alu.b);
      chkw("alu_sel", 32'(alu_sel), 32'(m_alu.sel));
    end
  endtask

  task automatic drive(input int p, input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] s);
    if (p == 0) begin req0_valid = v; req0_a = a; req0_b = b; req0_sel = s; end
    else        begin req1_valid = v; req1_a = a; req1_b = b; req1_sel = s; end
  endtask

  task automatic drain();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    repeat (4) step();
  endtask

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Issue one op on port p and stop at the first cycle its response is visible.
  task automatic do_op(input int p, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] s, output rsp_t got, output int waits);
    logic acc;
    drive(p, 1'b1, a, b, s);
    acc = 1'b0;
    waits = 0;
    while (!acc && waits < 20) begin
      step();
      waits++;
      acc = (p == 0) ? acc0 : acc1;
    end
    chk1("op_accepted", acc, 1'b1);
    if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    chk1("exec_no_rsp", rsp_valid, 1'b0);
    step();
    chk1("rsp_after_2_edges", rsp_valid, 1'b1);
    chk1("rsp_owner", rsp_id, p[0]);
    got = {rsp_result, rsp_zero, rsp_err};
  endtask

  initial begin
    rsp_t got;
    int   w;
    int   ng;
    int   gids[4];
    int   gcyc[4];
    int   exp_g[4];
    int   base;
    logic [W-1:0] snap;

    rst_n = 1'b0;
    rsp_ready = 1'b1;
    drive(0, 1'b0, '0, '0, 3'd0);
    drive(1, 1'b0, '0, '0, 3'd0);
    model_reset();
    @(negedge clk);
    step();
    step();
    rst_n = 1'b1;

    // Single op: 7 + 5.
    do_op(0, 32'd7, 32'd5, 3'b010, got, w);
    chkw("t1_wait", 32'(w), 32'd1);
    chkw("t1_result", got.result, 32'd12);
    chk1("t1_zero", got.zero, 1'b0);
    chk1("t1_err", got.err, 1'b0);
    step();

    // Zero, error and compare cases.
    do_op(0, 32'd9, 32'd9, 3'b100, got, w);
    chkw("t4_sub_result", got.result, 32'd0);
    chk1("t4_sub_zero", got.zero, 1'b1);
    step();
    do_op(1, 32'd20, 32'd3, 3'b011, got, w);
    chkw("t4_err_result", got.result, 32'd0);
    chk1("t4_err_zero", got.zero, 1'b1);
    chk1("t4_err_err", got.err, 1'b1);
    step();
    do_op(0, 32'd3, 32'd4, 3'b110, got, w);
    chkw("t4_slt_result", got.result, 32'd1);
    chk1("t4_slt_zero", got.zero, 1'b0);
    step();
    do_op(1, 32'hFFFF_FFFF, 32'd2, 3'b010, got, w);
    chkw("t4_wrap_result", got.result, 32'd1);
    step();
    do_op(0, 32'h8000_0000, 32'd1, 3'b110, got, w);
    chkw("t4_unsigned_lt", got.result, 32'd0);
    step();

    // Contention after reset: grants alternate 0,1,0,1 every third cycle.
    do_reset();
    rsp_ready = 1'b1;
    drive(0, 1'b1, 32'd10, 32'd1, 3'b010);
    drive(1, 1'b1, 32'd100, 32'd1, 3'b100);
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      step();
      if (acc0) begin gids[ng] = 0; gcyc[ng] = cyc; ng++; drive(0, 1'b1, 32'(11 + ng), 32'd1, 3'b010); end
      if (acc1) begin gids[ng] = 1; gcyc[ng] = cyc; ng++; drive(1, 1'b1, 32'(101 + ng), 32'd1, 3'b100); end
    end
    chkw("t2_grant_count", 32'(ng), 32'd4);
    exp_g = '{0, 1, 0, 1};
    for (int i = 0; i < ng && i < 4; i++) chkw("t2_grant_order", 32'(gids[i]), 32'(exp_g[i]));
    for (int i = 1; i < ng && i < 4; i++) chkw("t2_interval", 32'(gcyc[i] - gcyc[i-1]), 32'd3);
    drain();

    // Backpressure: response held, no grants, then handoff and the next grant.
    rsp_ready = 1'b0;
    do_op(0, 32'd100, 32'd23, 3'b010, got, w);
    chkw("t3_result", got.result, 32'd123);
    snap = rsp_result;
    drive(0, 1'b1, 32'd1, 32'd1, 3'b000);
    drive(1, 1'b1, 32'd5, 32'd6, 3'b101);
    for (int i = 0; i < 5; i++) begin
      step();
      chk1("t3_no_grant", acc0 | acc1, 1'b0);
      chk1("t3_valid_held", rsp_valid, 1'b1);
      chkw("t3_result_held", rsp_result, snap);
    end
    rsp_ready = 1'b1;
    step();
    chk1("t3_released", rsp_valid, 1'b0);
    step();
    chk1("t3_next_grant_port1", acc1, 1'b1);
    drain();

    // Reset during EXEC, then during RESP.
    drive(0, 1'b1, 32'd7, 32'd8, 3'b010);
    w = 0;
    acc0 = 1'b0;
    while (!acc0 && w < 10) begin step(); w++; end
    chk1("t5_accepted", acc0, 1'b1);
    req0_valid = 1'b0;
    drive(1, 1'b1, 32'd2, 32'd2, 3'b010);
    rst_n = 1'b0;
    #1;
    chk1("t5_rsp_valid_now", rsp_valid, 1'b0);
    chk1("t5_ready1_in_reset", req1_ready, 1'b0);
    chkw("t5_alu_inp1_now", alu_inp1, '0);
    step();
    step();
    rst_n = 1'b1;
    drive(0, 1'b1, 32'd4, 32'd4, 3'b000);
    step();
    chk1("t5_port0_first", acc0, 1'b1);
    drain();
    rsp_ready = 1'b0;
    do_op(1, 32'd6, 32'd7, 3'b101, got, w);
    chkw("t5_mul", got.result, 32'd42);
    rst_n = 1'b0;
    #1;
    chk1("t5_resp_dropped", rsp_valid, 1'b0);
    chkw("t5_result_cleared", rsp_result, '0);
    step();
    rst_n = 1'b1;
    drain();

    // Randomized traffic against the model.
    base = n_rsp;
    for (int c = 0; c < 30000 && (n_rsp - base) < 1000; c++) begin
      if (acc0 || !req0_valid) begin
        drive(0, ($urandom % 4) != 0,
              ($urandom % 2) ? $urandom : ($urandom % 8),
              ($urandom % 2) ? $urandom : ($urandom % 8), 3'($urandom % 8));
      end else if (($urandom % 16) == 0) begin
        req0_valid = 1'b0;
      end
      if (acc1 || !req1_valid) begin
        drive(1, ($urandom % 4) != 0,
              ($urandom % 2) ? $urandom : ($urandom % 8),
              ($urandom % 2) ? $urandom : ($urandom % 8), 3'($urandom % 8));
      end else if (($urandom % 16) == 0) begin
        req1_valid = 1'b0;
      end
      rsp_ready = ($urandom % 4) != 0;
      step();
    end
    chk1("rand_1000_responses", (n_rsp - base) >= 1000, 1'b1);
    drain();
    chkw("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
